// File: rtl/fpnew_pkg.sv
// fpnew_pkg: subset of the fpnew type definitions used by the request issuer
package fpnew_pkg;
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;
    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;
    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
    typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;
endpackage

// File: rtl/fpu_req_issuer_pkg.sv
// fpu_req_issuer_pkg: issuer FSM states, rounding-mode resolution, fflags packing
package fpu_req_issuer_pkg;
    import fpnew_pkg::*;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_e;
    function automatic roundmode_e resolve_rm(input roundmode_e rm, input logic [2:0] frm);
        return rm != DYN ? rm : (frm > 3'd4 ? RNE : roundmode_e'(frm));
    endfunction
    function automatic logic [4:0] pack_fflags(input status_t s);
        return {s.NV, s.DZ, s.OF, s.UF, s.NX};
    endfunction
endpackage

// File: rtl/fpu_req_issuer.sv
// fpu_req_issuer: single-outstanding initiator for the fpnew_top request/response handshake
//   req_*   : issue-stage request (valid/ready), frm_i resolves DYN rounding at accept
//   fpu_*   : registered request to the FPU, result handshake back, fpu_flush_o
//   wb_*    : captured result/fflags/tag for writeback (valid/ready), wb_err_o on timeout
//   FPU_REQ_TIMEOUT_EN enables a TIMEOUT_CYCLES watchdog over REQ/WAIT
module fpu_req_issuer
    import fpnew_pkg::*;
    import fpu_req_issuer_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned TAG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [2:0][WIDTH-1:0]   req_operands_i,
    input  roundmode_e              req_rnd_mode_i,
    input  operation_e              req_op_i,
    input  logic                    req_op_mod_i,
    input  fp_format_e              req_src_fmt_i,
    input  fp_format_e              req_dst_fmt_i,
    input  int_format_e             req_int_fmt_i,
    input  logic [TAG_W-1:0]        req_tag_i,
    input  logic [2:0]              frm_i,
    input  logic                    flush_i,
    output logic [2:0][WIDTH-1:0]   fpu_operands_o,
    output roundmode_e              fpu_rnd_mode_o,
    output operation_e              fpu_op_o,
    output logic                    fpu_op_mod_o,
    output fp_format_e              fpu_src_fmt_o,
    output fp_format_e              fpu_dst_fmt_o,
    output int_format_e             fpu_int_fmt_o,
    output logic [TAG_W-1:0]        fpu_tag_o,
    output logic                    fpu_vectorial_op_o,
    output logic                    fpu_in_valid_o,
    input  logic                    fpu_in_ready_i,
    output logic                    fpu_flush_o,
    input  logic [WIDTH-1:0]        fpu_result_i,
    input  status_t                 fpu_status_i,
    input  logic [TAG_W-1:0]        fpu_tag_i,
    input  logic                    fpu_out_valid_i,
    output logic                    fpu_out_ready_o,
    input  logic                    fpu_busy_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [WIDTH-1:0]        wb_result_o,
    output logic [4:0]              wb_fflags_o,
    output logic [TAG_W-1:0]        wb_tag_o,
    output logic                    wb_err_o
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    state_e state_q, state_d;
    logic   rst_q, tmo_q, tmo_hit, tmo_take, accept, capture;
    assign accept             = state_q == IDLE && req_valid_i && !flush_i;
    assign capture            = state_q == WAIT && fpu_out_valid_i && !flush_i;
    assign req_ready_o        = state_q == IDLE;
    assign fpu_in_valid_o     = state_q == REQ;
    assign fpu_out_ready_o    = state_q == WAIT || state_q == DRAIN;
    assign wb_valid_o         = state_q == RESP;
    assign fpu_vectorial_op_o = 1'b0;
    // timeout flush is registered so fpu_in_ready_i/fpu_out_valid_i never reach fpu_flush_o combinationally
    assign fpu_flush_o        = !rst_i && (flush_i || rst_q || tmo_q);
    always_comb begin
        state_d  = state_q;
        tmo_take = 1'b0;
        case (state_q)
            IDLE:  state_d = accept ? REQ : IDLE;
            REQ: begin
                tmo_take = !flush_i && !fpu_in_ready_i && tmo_hit;
                state_d  = flush_i ? IDLE : fpu_in_ready_i ? WAIT : tmo_hit ? RESP : REQ;
            end
            WAIT: begin
                tmo_take = !flush_i && !fpu_out_valid_i && tmo_hit;
                state_d  = flush_i ? DRAIN : (fpu_out_valid_i || tmo_hit) ? RESP : WAIT;
            end
            RESP:  state_d = (flush_i || wb_ready_i) ? IDLE : RESP;
            DRAIN: state_d = (!fpu_busy_i || fpu_out_valid_i) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) rst_q <= rst_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            tmo_q          <= 1'b0;
            fpu_operands_o <= '0;
            fpu_rnd_mode_o <= RNE;
            fpu_op_o       <= FMADD;
            fpu_op_mod_o   <= 1'b0;
            fpu_src_fmt_o  <= FP32;
            fpu_dst_fmt_o  <= FP32;
            fpu_int_fmt_o  <= INT8;
            fpu_tag_o      <= '0;
            wb_result_o    <= '0;
            wb_fflags_o    <= '0;
            wb_tag_o       <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_take;
            if (accept) begin
                fpu_operands_o <= req_operands_i;
                fpu_rnd_mode_o <= resolve_rm(req_rnd_mode_i, frm_i);
                fpu_op_o       <= req_op_i;
                fpu_op_mod_o   <= req_op_mod_i;
                fpu_src_fmt_o  <= req_src_fmt_i;
                fpu_dst_fmt_o  <= req_dst_fmt_i;
                fpu_int_fmt_o  <= req_int_fmt_i;
                fpu_tag_o      <= req_tag_i;
            end
            if (tmo_take) begin
                wb_result_o <= '0;
                wb_fflags_o <= '0;
                wb_tag_o    <= fpu_tag_o;
            end else if (capture) begin
                wb_result_o <= fpu_result_i;
                wb_fflags_o <= pack_fflags(fpu_status_i);
                wb_tag_o    <= fpu_tag_i;
            end
        end
    end
`ifdef FPU_REQ_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q;
    assign tmo_hit = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    // cleared while idle, so it starts from zero on every entry to REQ
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == IDLE) cnt_q <= '0;
        else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) wb_err_o <= 1'b0;
        else if (tmo_take) wb_err_o <= 1'b1;
        else if (capture) wb_err_o <= 1'b0;
    end
`else
    assign tmo_hit  = 1'b0;
    assign wb_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_req_issuer.sv
// tb_fpu_req_issuer: directed and randomized checks of fpu_req_issuer against a behavioural FPU/issue model
module tb_fpu_req_issuer;
    import fpnew_pkg::*;
    logic              clk, rst;
    logic              req_valid, req_ready, req_op_mod, frm_dummy;
    logic [2:0][63:0]  req_operands, fpu_operands;
    roundmode_e        req_rnd_mode, fpu_rnd_mode;
    operation_e        req_op, fpu_op;
    fp_format_e        req_src_fmt, req_dst_fmt, fpu_src_fmt, fpu_dst_fmt;
    int_format_e       req_int_fmt, fpu_int_fmt;
    logic [4:0]        req_tag, fpu_tag_out, fpu_tag_in, wb_tag, wb_fflags;
    logic [2:0]        frm;
    logic              flush, fpu_op_mod, fpu_vec, fpu_in_valid, fpu_in_ready, fpu_flush;
    logic [63:0]       fpu_result, wb_result;
    status_t           fpu_status;
    logic              fpu_out_valid, fpu_out_ready, fpu_busy, wb_valid, wb_ready, wb_err;
    int                checks = 0;
    int                errors = 0;

    fpu_req_issuer #(.WIDTH(64), .TAG_W(5), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
        .req_rnd_mode_i(req_rnd_mode), .req_op_i(req_op), .req_op_mod_i(req_op_mod),
        .req_src_fmt_i(req_src_fmt), .req_dst_fmt_i(req_dst_fmt), .req_int_fmt_i(req_int_fmt),
        .req_tag_i(req_tag), .frm_i(frm), .flush_i(flush),
        .fpu_operands_o(fpu_operands), .fpu_rnd_mode_o(fpu_rnd_mode), .fpu_op_o(fpu_op),
        .fpu_op_mod_o(fpu_op_mod), .fpu_src_fmt_o(fpu_src_fmt), .fpu_dst_fmt_o(fpu_dst_fmt),
        .fpu_int_fmt_o(fpu_int_fmt), .fpu_tag_o(fpu_tag_out), .fpu_vectorial_op_o(fpu_vec),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready), .fpu_flush_o(fpu_flush),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready), .fpu_busy_i(fpu_busy),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result),
        .wb_fflags_o(wb_fflags), .wb_tag_o(wb_tag), .wb_err_o(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DYN takes the CSR value; CSR values above RMM are reserved and fall back to RNE
    function automatic logic [2:0] model_rm(input logic [2:0] rm, input logic [2:0] f);
        if (rm != 3'd7) return rm;
        return (f <= 3'd4) ? f : 3'd0;
    endfunction

    task automatic txn(input logic [2:0][63:0] ops, input logic [2:0] rm, input logic [2:0] f,
                       input logic [3:0] op, input logic [4:0] tag, input int in_dly, input int lat,
                       input int wb_dly, input logic [63:0] res, input logic [4:0] fl, input logic [4:0] rtag);
        logic [2:0] erm;
        logic       mod;
        logic [2:0] sf, df;
        logic [1:0] itf;
        erm = model_rm(rm, f);
        mod = 1'($urandom);
        sf  = 3'($urandom_range(0, 4));
        df  = 3'($urandom_range(0, 4));
        itf = 2'($urandom_range(0, 3));
        chk("idle_ready", req_ready, 1);
        req_valid = 1; req_operands = ops; req_rnd_mode = roundmode_e'(rm); req_op = operation_e'(op);
        req_op_mod = mod; req_src_fmt = fp_format_e'(sf); req_dst_fmt = fp_format_e'(df);
        req_int_fmt = int_format_e'(itf); req_tag = tag; frm = f;
        tick();
        req_valid = 0; req_operands = ~ops; frm = 3'($urandom); req_tag = ~tag;
        #1;
        chk("req_op", fpu_op, op);
        chk("req_mod", fpu_op_mod, mod);
        chk("req_fmts", {fpu_src_fmt, fpu_dst_fmt, fpu_int_fmt}, {sf, df, itf});
        chk("req_tag", fpu_tag_out, tag);
        chk("req_vec", fpu_vec, 0);
        for (int i = 0; i <= in_dly; i++) begin
            fpu_in_ready = (i == in_dly);
            #1;
            chk("req_valid", fpu_in_valid, 1);
            chk("req_operands", fpu_operands, ops);
            chk("req_rm", fpu_rnd_mode, erm);
            chk("req_busy_ready", req_ready, 0);
            tick();
        end
        fpu_in_ready = 0;
        #1;
        chk("in_valid_drop", fpu_in_valid, 0);
        for (int i = 0; i < lat; i++) begin
            chk("wait_out_ready", fpu_out_ready, 1);
            chk("wait_no_wb", wb_valid, 0);
            chk("wait_busy_ready", req_ready, 0);
            tick();
        end
        fpu_status = '{NV: fl[4], DZ: fl[3], OF: fl[2], UF: fl[1], NX: fl[0]};
        fpu_result = res; fpu_tag_in = rtag; fpu_out_valid = 1;
        #1;
        chk("wait_out_ready", fpu_out_ready, 1);
        tick();
        fpu_out_valid = 0; fpu_result = {$urandom, $urandom}; fpu_tag_in = 5'($urandom); fpu_status = '0;
        for (int i = 0; i <= wb_dly; i++) begin
            wb_ready = (i == wb_dly);
            #1;
            chk("wb_valid", wb_valid, 1);
            chk("wb_result", wb_result, res);
            chk("wb_fflags", wb_fflags, fl);
            chk("wb_tag", wb_tag, rtag);
            chk("wb_err", wb_err, 0);
            chk("resp_out_ready", fpu_out_ready, 0);
            chk("resp_busy_ready", req_ready, 0);
            tick();
        end
        wb_ready = 0;
        #1;
        chk("wb_done", wb_valid, 0);
        chk("back_idle", req_ready, 1);
    endtask

    task automatic go_wait(input logic [4:0] tag);
        req_valid = 1; req_rnd_mode = RNE; req_op = MUL; req_tag = tag;
        tick();
        req_valid = 0; fpu_in_ready = 1;
        tick();
        fpu_in_ready = 0;
        #1;
    endtask

    initial begin
        logic [2:0][63:0] ops;
        logic [4:0]       t;
        rst = 1; req_valid = 0; req_operands = '0; req_rnd_mode = RNE; req_op = FMADD; req_op_mod = 0;
        req_src_fmt = FP64; req_dst_fmt = FP64; req_int_fmt = INT32; req_tag = '0; frm = '0; flush = 0;
        fpu_in_ready = 0; fpu_result = '0; fpu_status = '0; fpu_tag_in = '0; fpu_out_valid = 0;
        fpu_busy = 0; wb_ready = 0; frm_dummy = 0;
        tick();
        tick();
        chk("rst_ready", req_ready, 1);
        chk("rst_in_valid", fpu_in_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_flush", fpu_flush, 0);
        chk("rst_err", wb_err, 0);
        chk("rst_operands", fpu_operands, 0);
        chk("rst_wb_result", wb_result, 0);
        rst = 0;
        #1;
        chk("rst_release_flush", fpu_flush, 1);
        tick();
        chk("rst_release_flush_end", fpu_flush, 0);

        ops = {64'h1, 64'h4000000000000000, 64'h3ff0000000000000};
        txn(ops, 3'd0, 3'd0, 4'd2, 5'd3, 1, 5, 0, 64'h4008000000000000, 5'b00001, 5'd3);
        txn(ops, 3'd7, 3'd1, 4'd3, 5'd4, 0, 1, 0, 64'h0123456789abcdef, 5'b10000, 5'd4);
        txn(ops, 3'd7, 3'd7, 4'd4, 5'd5, 0, 2, 1, 64'hfedcba9876543210, 5'b01000, 5'd5);
        txn({64'hdead, 64'hbeef, 64'hcafe}, 3'd3, 3'd6, 4'd0, 5'd6, 10, 2, 4, 64'h55aa, 5'b00110, 5'd9);

        for (int n = 0; n < 12; n++) begin
            ops = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            t = 5'($urandom);
            txn(ops, 3'($urandom_range(0, 5) == 5 ? 7 : $urandom_range(0, 4)), 3'($urandom),
                4'($urandom_range(0, 14)), t, $urandom_range(0, 3), $urandom_range(0, 4),
                $urandom_range(0, 3), {$urandom, $urandom}, 5'($urandom),
                ($urandom_range(0, 3) == 0) ? 5'($urandom) : t);
        end

        go_wait(5'd10);
        fpu_busy = 1; flush = 1;
        #1;
        chk("wait_flush_pulse", fpu_flush, 1);
        tick();
        flush = 0;
        #1;
        chk("wait_flush_end", fpu_flush, 0);
        for (int i = 0; i < 3; i++) begin
            chk("drain_out_ready", fpu_out_ready, 1);
            chk("drain_no_accept", req_ready, 0);
            chk("drain_no_wb", wb_valid, 0);
            tick();
        end
        fpu_out_valid = 1; fpu_result = 64'h1234;
        tick();
        fpu_out_valid = 0; fpu_busy = 0;
        #1;
        chk("drain_exit_idle", req_ready, 1);
        chk("drain_discard", wb_valid, 0);

        req_valid = 1; flush = 1;
        #1;
        chk("idle_flush_pulse", fpu_flush, 1);
        tick();
        req_valid = 0; flush = 0;
        #1;
        chk("idle_flush_no_accept", fpu_in_valid, 0);
        chk("idle_flush_ready", req_ready, 1);

        req_valid = 1; req_tag = 5'd11;
        tick();
        req_valid = 0; flush = 1;
        #1;
        chk("req_flush_pulse", fpu_flush, 1);
        tick();
        flush = 0;
        #1;
        chk("req_flush_drop", fpu_in_valid, 0);
        chk("req_flush_idle", req_ready, 1);

        go_wait(5'd12);
        flush = 1; fpu_out_valid = 1; fpu_result = 64'h777;
        tick();
        flush = 0; fpu_out_valid = 0;
        #1;
        chk("wait_flush_result_discard", wb_valid, 0);
        tick();
        chk("wait_flush_result_idle", req_ready, 1);

        go_wait(5'd13);
        fpu_out_valid = 1;
        tick();
        fpu_out_valid = 0;
        #1;
        chk("resp_before_flush", wb_valid, 1);
        flush = 1;
        tick();
        flush = 0;
        #1;
        chk("resp_flush_drop", wb_valid, 0);
        chk("resp_flush_idle", req_ready, 1);

        go_wait(5'd14);
        fpu_out_valid = 1;
        tick();
        fpu_out_valid = 0; rst = 1;
        tick();
        chk("resp_reset_drop", wb_valid, 0);
        chk("resp_reset_ready", req_ready, 1);
        chk("resp_reset_flush_low", fpu_flush, 0);
        rst = 0;
        #1;
        chk("reset_release_pulse", fpu_flush, 1);
        tick();
        chk("reset_release_pulse_end", fpu_flush, 0);

`ifdef FPU_REQ_TIMEOUT_EN
        req_valid = 1; req_tag = 5'd21;
        tick();
        req_valid = 0;
        for (int i = 0; i < 16; i++) begin
            chk("tmo_no_flush_yet", fpu_flush, 0);
            chk("tmo_no_wb_yet", wb_valid, 0);
            tick();
        end
        chk("tmo_flush_pulse", fpu_flush, 1);
        chk("tmo_wb_valid", wb_valid, 1);
        chk("tmo_wb_err", wb_err, 1);
        chk("tmo_wb_result", wb_result, 0);
        chk("tmo_wb_fflags", wb_fflags, 0);
        chk("tmo_wb_tag", wb_tag, 21);
        tick();
        chk("tmo_flush_end", fpu_flush, 0);
        chk("tmo_wb_hold", wb_valid, 1);
        wb_ready = 1;
        tick();
        wb_ready = 0;
        #1;
        chk("tmo_done", req_ready, 1);
`else
        req_valid = 1; req_tag = 5'd21;
        tick();
        req_valid = 0;
        repeat (40) tick();
        chk("no_tmo_still_req", fpu_in_valid, 1);
        chk("no_tmo_no_wb", wb_valid, 0);
        chk("no_tmo_no_flush", fpu_flush, 0);
        flush = 1;
        tick();
        flush = 0;
        #1;
        chk("no_tmo_flush_idle", req_ready, 1);
`endif
        chk("err_tied_after", wb_err | frm_dummy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
